// File: rtl/temporal_encoder.sv
// Race-logic encoder: turns per-channel binary operands into one timed spike per gamma
// cycle and sequences the gamma reset / evaluation window for downstream comparators.
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    grst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*VAL_W-1:0] in_value,
    output logic [NUM_CH-1:0]       spike,
    output logic                    gamma_rst,
    output logic                    gamma_last
);

    localparam int P       = GAMMA_CYCLE_WIDTH;
    localparam int OFF_W   = $clog2(P);
    localparam int NULL_TH = P - 1 - PULSE_WIDTH;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(P - 1);
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

    if (PULSE_WIDTH < 1 || PULSE_WIDTH > P - 2) begin : g_bad_pulse_width
        $error("temporal_encoder: PULSE_WIDTH must lie in 1..GAMMA_CYCLE_WIDTH-2");
    end

    typedef enum logic [1:0] {S_IDLE, S_GRST, S_RUN} state_t;

    state_t                    r_state, w_state_nxt;
    logic [OFF_W-1:0]          r_offset, w_offset_nxt;
    logic [NUM_CH*VAL_W-1:0]   r_val, w_val_nxt;
    logic [NUM_CH-1:0]         r_spike, w_spike_nxt;
    logic                      r_in_ready, r_gamma_rst, r_gamma_last;
    logic                      w_accept;

    // Spike window for value v is offsets v+1 .. v+PULSE_WIDTH; values too late to fit are null.
    function automatic logic spike_at(input logic [VAL_W-1:0] v, input logic [OFF_W-1:0] off);
        int vi;
        int oi;
        vi = int'(v);
        oi = int'(off);
        return (vi <= NULL_TH) && (oi >= vi + 1) && (oi <= vi + PULSE_WIDTH);
    endfunction

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_val_nxt    = r_val;
        case (r_state)
            S_IDLE: begin
                w_offset_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_GRST;
                    w_val_nxt   = in_value;
                end
            end
            S_GRST: begin
                w_state_nxt  = S_RUN;
                w_offset_nxt = OFF_ONE;
            end
            S_RUN: begin
                if (r_offset == OFF_LAST) begin
                    w_offset_nxt = '0;
                    if (w_accept) begin
                        w_state_nxt = S_GRST;
                        w_val_nxt   = in_value;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_offset_nxt = r_offset + OFF_ONE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_offset_nxt = '0;
            end
        endcase
    end

    // Outputs are precomputed from next-state values so each flop matches its cycle's offset.
    always_comb begin
        w_spike_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_spike_nxt[i] = (w_state_nxt == S_RUN) &&
                             spike_at(w_val_nxt[i*VAL_W +: VAL_W], w_offset_nxt);
        end
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_state      <= S_IDLE;
            r_offset     <= '0;
            r_val        <= '0;
            r_spike      <= '0;
            r_gamma_rst  <= 1'b1;
            r_gamma_last <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_offset     <= w_offset_nxt;
            r_val        <= w_val_nxt;
            r_spike      <= w_spike_nxt;
            r_gamma_rst  <= (w_state_nxt != S_RUN);
            r_gamma_last <= (w_state_nxt == S_RUN) && (w_offset_nxt == OFF_LAST);
            r_in_ready   <= (w_state_nxt == S_IDLE) ||
                            ((w_state_nxt == S_RUN) && (w_offset_nxt == OFF_LAST));
        end
    end

    assign spike      = r_spike;
    assign gamma_rst  = r_gamma_rst;
    assign gamma_last = r_gamma_last;
    assign in_ready   = r_in_ready;

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench for temporal_encoder (P=16, PULSE_WIDTH=8, two channels): expected spike
// masks per gamma are queued at accept time and compared by a monitor at each gamma_last.
module tb_temporal_encoder;

    logic       aclk;
    logic       grst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic [1:0] spike;
    logic       gamma_rst;
    logic       gamma_last;

    typedef struct {
        logic [15:0] m0;
        logic [15:0] m1;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          idx    = 0;
    logic [15:0] tr0    = '0;
    logic [15:0] tr1    = '0;

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH(8),
        .NUM_CH(2)
    ) dut (
        .aclk(aclk),
        .grst_n(grst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_value(in_value),
        .spike(spike),
        .gamma_rst(gamma_rst),
        .gamma_last(gamma_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: records spikes by offset, compares against the queued masks at gamma_last.
    always @(negedge aclk) begin
        if (grst_n) begin
            if (gamma_rst) begin
                idx = 0;
                tr0 = '0;
                tr1 = '0;
                chk("spike_low_in_gamma_rst", 32'(spike), 32'd0);
            end else begin
                idx++;
                if (idx <= 15) begin
                    tr0[idx] = spike[0];
                    tr1[idx] = spike[1];
                end
                chk("in_ready_only_at_last", 32'(in_ready), 32'(gamma_last));
                if (gamma_last) begin
                    chk("gamma_last_offset", 32'(idx), 32'd15);
                    if (sb.size() == 0) begin
                        chk("gamma_without_accept", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("ch0_spike_mask", 32'(tr0), 32'(e.m0));
                        chk("ch1_spike_mask", 32'(tr1), 32'(e.m1));
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] v0, input logic [3:0] v1,
                        input logic [15:0] m0, input logic [15:0] m1);
        int n;
        exp_t e;
        n = 0;
        @(negedge aclk);
        in_valid = 1'b1;
        in_value = {v1, v0};
        while (!in_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("accept_timeout", 32'(n >= 100), 32'd0);
        e.m0 = m0;
        e.m1 = m1;
        sb.push_back(e);
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        in_value = 8'hAA;
        @(negedge aclk);
        chk("grst_after_accept", 32'({gamma_rst, in_ready}), 32'b10);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!gamma_last && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("gamma_last_timeout", 32'(n >= 100), 32'd0);
        @(negedge aclk);
        chk("idle_after_gamma", 32'({in_ready, gamma_rst, gamma_last}), 32'b110);
    endtask

    initial begin
        int n;
        grst_n   = 1'b1;
        in_valid = 1'b0;
        in_value = '0;

        // 1: asynchronous reset, checked mid-cycle without a clock edge
        #3 grst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({spike, gamma_rst, in_ready, gamma_last}), 32'b00110);
        repeat (2) @(posedge aclk);
        #2 grst_n = 1'b1;

        // 2: {2,5}: exact latencies relative to accept
        send(4'd2, 4'd5, 16'h07F8, 16'h3FC0);
        n = 1;
        while (!gamma_last && n < 40) begin
            @(negedge aclk);
            n++;
        end
        chk("gamma_last_latency", 32'(n), 32'd16);
        wait_idle();

        // 3: null encodings still run a full gamma
        send(4'd8, 4'd15, 16'h0000, 16'h0000);
        wait_idle();

        // 4 and 5: {0,7} then back-to-back vectors with in_valid held
        send(4'd0, 4'd7, 16'h01FE, 16'hFF00);
        send(4'd3, 4'd6, 16'h0FF0, 16'h7F80);
        send(4'd7, 4'd7, 16'hFF00, 16'hFF00);
        send(4'd2, 4'd9, 16'h07F8, 16'h0000);
        wait_idle();

        // 6: reset while ch0 spike is high at offset 5
        send(4'd2, 4'd5, 16'h07F8, 16'h3FC0);
        repeat (5) @(negedge aclk);
        chk("spike0_high_offset5", 32'(spike[0]), 32'd1);
        #2 grst_n = 1'b0;
        #1;
        chk("midop_reset_outputs", 32'({spike, gamma_rst}), 32'b001);
        sb.delete();
        @(posedge aclk);
        #2 grst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            chk("quiet_after_reset", 32'({spike, gamma_rst, in_ready, gamma_last}), 32'b00110);
        end

        send(4'd1, 4'd4, 16'h03FC, 16'h1FE0);
        wait_idle();

        repeat (3) @(negedge aclk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
